width_conv_arbiter: RTL

WIDTH_CONV_ARBITER -- requirements
Module: width_conv_arbiter

---
 rtl/width_conv_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/width_conv_arbiter.sv
// Two-source round-robin arbiter feeding a shared 24->128 width converter in 16-beat alignment groups.
// Optional macro PAD_FLUSH_EN: an early sx_last zero-pads the rest of the group.
module width_conv_arbiter #(
    parameter int DATA_W      = 24,
    parameter int GROUP_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic              conv_valid,
    output logic [DATA_W-1:0] conv_data,
    output logic              conv_src,
    output logic              conv_sof,
    output logic [1:0]        state_dbg
);
    // Handshake: a beat transfers on a rising edge where sx_valid and sx_ready are both 1;
    // ready depends only on state, never on valid, and is 0 outside the owning grant.
    localparam int CNT_W = $clog2(GROUP_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GROUP_BEATS - 1);

`ifdef PAD_FLUSH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2, PAD = 2'd3} state_t;
    logic hs_last;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;
    logic unused_last;
    assign unused_last = s0_last | s1_last;
`endif

    state_t            state, state_n;
    logic              ptr, ptr_n;     // 1: source 1 wins a tie
    logic [CNT_W-1:0]  cnt;
    logic              fwd;
    logic [DATA_W-1:0] fwd_data;

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        fwd      = 1'b0;
        fwd_data = s0_data;
`ifdef PAD_FLUSH_EN
        hs_last  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (s0_valid && (!s1_valid || !ptr)) state_n = GRANT0;
                else if (s1_valid)                   state_n = GRANT1;
            end
            GRANT0: begin
                s0_ready = 1'b1;
                fwd      = s0_valid;
`ifdef PAD_FLUSH_EN
                hs_last  = s0_last;
`endif
            end
            GRANT1: begin
                s1_ready = 1'b1;
                fwd      = s1_valid;
                fwd_data = s1_data;
`ifdef PAD_FLUSH_EN
                hs_last  = s1_last;
`endif
            end
`ifdef PAD_FLUSH_EN
            PAD: begin
                fwd      = 1'b1;
                fwd_data = '0;
            end
`endif
            default: state_n = IDLE;
        endcase

        // conv_src already names the group owner by the time its final beat is forwarded
        if (fwd) begin
            if (cnt == LAST_BEAT) begin
                state_n = IDLE;
                ptr_n   = ~conv_src;
            end
`ifdef PAD_FLUSH_EN
            else if (hs_last) begin
                state_n = PAD;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            conv_valid <= 1'b0;
            conv_data  <= '0;
            conv_src   <= 1'b0;
            conv_sof   <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            conv_valid <= fwd;
            conv_sof   <= fwd && (cnt == '0);
            if (fwd) begin
                conv_data <= fwd_data;
                cnt       <= cnt + 1'b1;
                if (cnt == '0) conv_src <= (state == GRANT1);
            end
        end
    end

    assign state_dbg = state;

endmodule
